// File: rtl/vec_player_if.sv
// vec_player_if: the control, load and status bundle of the vector player.
//   master: drives the vector load port, num_vec and start; watches status.
//   slave : the player itself.
//   load_en/load_addr/load_a/load_y : write one {a, y} slot
//   num_vec/start                   : run length and one-cycle run request
//   busy/done/pass/fail             : run status
//   fail_index/fail_got             : first mismatching slot and the y seen there
interface vec_player_if #(
    parameter int WIDTH_A = 1,
    parameter int WIDTH_Y = 1,
    parameter int DEPTH   = 16
);
    localparam int AW = $clog2(DEPTH);

    logic               load_en;
    logic [AW-1:0]      load_addr;
    logic [WIDTH_A-1:0] load_a;
    logic [WIDTH_Y-1:0] load_y;
    logic [AW:0]        num_vec;
    logic               start;
    logic               busy;
    logic               done;
    logic               pass;
    logic               fail;
    logic [AW-1:0]      fail_index;
    logic [WIDTH_Y-1:0] fail_got;

    modport master (
        output load_en, load_addr, load_a, load_y, num_vec, start,
        input  busy, done, pass, fail, fail_index, fail_got
    );

    modport slave (
        input  load_en, load_addr, load_a, load_y, num_vec, start,
        output busy, done, pass, fail, fail_index, fail_got
    );
endinterface

// File: rtl/vec_player.sv
// vec_player: plays stored stimulus vectors into a unit under test and
// compares its response against stored expected values.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   ctl          : vec_player_if slave (load port, start, status)
//   a            : registered stimulus to the unit under test
//   y            : response from the unit under test, checked LATENCY
//                  cycles after the matching stimulus
module vec_player #(
    parameter int WIDTH_A = 1,
    parameter int WIDTH_Y = 1,
    parameter int DEPTH   = 16,
    parameter int LATENCY = 0
) (
    input  logic               clock,
    input  logic               reset,
    vec_player_if.slave        ctl,
    output logic [WIDTH_A-1:0] a,
    input  logic [WIDTH_Y-1:0] y
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_PASS, S_FAIL} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d, nxt_idx, last_idx;
    logic [NW-1:0]      num_q, num_d;
    logic [WIDTH_A-1:0] a_q, a_d;
    logic [AW-1:0]      fidx_q, fidx_d;
    logic [WIDTH_Y-1:0] fgot_q, fgot_d;

    // Compare pipeline: stage 0 tracks the vector currently on `a`,
    // stage LATENCY is the one whose response is on `y` this cycle.
    logic [LATENCY:0]   vld_q, vld_d;
    logic [AW-1:0]      pidx_q [LATENCY+1];
    logic [AW-1:0]      pidx_d [LATENCY+1];
    logic [WIDTH_Y-1:0] pexp_q [LATENCY+1];
    logic [WIDTH_Y-1:0] pexp_d [LATENCY+1];

    logic [WIDTH_A-1:0] mem_a [DEPTH];
    logic [WIDTH_Y-1:0] mem_y [DEPTH];

    logic busy, start_ok, cmp_vld, cmp_last, mismatch;

    assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign start_ok = ctl.start && (ctl.num_vec != '0) && (ctl.num_vec <= NW'(DEPTH));
    assign last_idx = AW'(num_q - 1'b1);
    assign cmp_vld  = vld_q[LATENCY];
    assign cmp_last = (pidx_q[LATENCY] == last_idx);
    assign mismatch = (y != pexp_q[LATENCY]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nxt_idx = idx_q + 1'b1;
        num_d   = num_q;
        a_d     = a_q;
        fidx_d  = fidx_q;
        fgot_d  = fgot_q;
        vld_d   = vld_q;
        pidx_d  = pidx_q;
        pexp_d  = pexp_q;

        for (int k = 1; k <= LATENCY; k++) begin
            vld_d[k]  = vld_q[k-1];
            pidx_d[k] = pidx_q[k-1];
            pexp_d[k] = pexp_q[k-1];
        end
        vld_d[0] = 1'b0;

        case (state_q)
            S_IDLE, S_PASS, S_FAIL: begin
                if (start_ok) begin
                    state_d   = S_RUN;
                    idx_d     = '0;
                    num_d     = ctl.num_vec;
                    fidx_d    = '0;
                    fgot_d    = '0;
                    a_d       = mem_a[0];
                    vld_d[0]  = 1'b1;
                    pidx_d[0] = '0;
                    pexp_d[0] = mem_y[0];
                end
            end
            S_RUN: begin
                if (idx_q != last_idx) begin
                    idx_d     = nxt_idx;
                    a_d       = mem_a[nxt_idx];
                    vld_d[0]  = 1'b1;
                    pidx_d[0] = nxt_idx;
                    pexp_d[0] = mem_y[nxt_idx];
                end else begin
                    // `a` keeps the last vector while the pipeline empties.
                    state_d = S_DRAIN;
                end
            end
            default: ;
        endcase

        // The compare outcome overrides the issue path: with LATENCY=0 the
        // last compare lands on the same edge that would enter DRAIN.
        if (busy && cmp_vld) begin
            if (mismatch) begin
                state_d = S_FAIL;
                fidx_d  = pidx_q[LATENCY];
                fgot_d  = y;
                vld_d   = '0;
            end else if (cmp_last) begin
                state_d = S_PASS;
                vld_d   = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            num_q   <= '0;
            a_q     <= '0;
            fidx_q  <= '0;
            fgot_q  <= '0;
            vld_q   <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                pidx_q[k] <= '0;
                pexp_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            a_q     <= a_d;
            fidx_q  <= fidx_d;
            fgot_q  <= fgot_d;
            vld_q   <= vld_d;
            pidx_q  <= pidx_d;
            pexp_q  <= pexp_d;
        end
    end

    // Vector memory survives reset; writes are locked out while a run is live.
    always_ff @(posedge clock) begin
        if (!reset && ctl.load_en && !busy) begin
            mem_a[ctl.load_addr] <= ctl.load_a;
            mem_y[ctl.load_addr] <= ctl.load_y;
        end
    end

    assign a              = a_q;
    assign ctl.busy       = busy;
    assign ctl.pass       = (state_q == S_PASS);
    assign ctl.fail       = (state_q == S_FAIL);
    assign ctl.done       = (state_q == S_PASS) || (state_q == S_FAIL);
    assign ctl.fail_index = fidx_q;
    assign ctl.fail_got   = fgot_q;
endmodule
